// File: rtl/puf_challenge_ctrl.sv
// Challenge/response sequencer for a bank of arbiter PUF chains: LFSR challenge
// generation, race launch and settle timing, XOR combining, and word packing.
module puf_challenge_ctrl #(
    parameter int N      = 128,
    parameter int K      = 4,
    parameter int SETTLE = 8,
    parameter int RESP_W = 32,
    parameter logic [N-1:0] SEED = 128'h1,
    parameter logic [N-1:0] TAPS = 128'hA000_0028_0000_0000_0000_0000_0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              seed_load,
    input  logic [N-1:0]      seed_in,
    output logic [N-1:0]      challenge,
    output logic              race,
    output logic              arb_reset,
    input  logic [K-1:0]      arb_resp,
    output logic [RESP_W-1:0] resp_word,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy
);

    localparam int CW = $clog2(RESP_W + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        IDLE, APPLY, LAUNCH, WAIT, SAMPLE, OUTPUT
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     bit_cnt;
    logic [SW-1:0]     settle_cnt;
    logic [RESP_W-1:0] shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: the challenge only moves on the SAMPLE exit edge, so it is
    // stable for the whole race of the bit it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            challenge  <= SEED;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            shift      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        challenge <= (seed_in == '0) ? N'(1) : seed_in;
                    end else if (start) begin
                        bit_cnt <= '0;
                    end
                end
                LAUNCH: settle_cnt <= '0;
                WAIT:   settle_cnt <= settle_cnt + SW'(1);
                SAMPLE: begin
                    shift     <= {shift[RESP_W-2:0], ^arb_resp};
                    challenge <= {challenge[N-2:0], ^(challenge & TAPS)};
                    bit_cnt   <= bit_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        race       = 1'b0;
        arb_reset  = 1'b1;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!seed_load && start) begin
                    state_next = APPLY;
                end
            end
            APPLY: state_next = LAUNCH;
            LAUNCH: begin
                race       = 1'b1;
                arb_reset  = 1'b0;
                state_next = WAIT;
            end
            WAIT: begin
                race      = 1'b1;
                arb_reset = 1'b0;
                if (settle_cnt == SW'(SETTLE - 1)) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                race       = 1'b1;
                arb_reset  = 1'b0;
                state_next = (bit_cnt == CW'(RESP_W - 1)) ? OUTPUT : APPLY;
            end
            OUTPUT: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign resp_word = shift;
    assign busy      = (state != IDLE);

endmodule
